// File: rtl/sr_ff_checker.sv
// Self-contained checker for an SR flip-flop under test: predicts the DUT's next q from
// the same s/r/clear/preset stimulus and flags mismatches, illegal commands and counts.
module sr_ff_checker #(
    parameter int CNT_W       = 8,
    parameter bit HALT_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             dut_clr,
    input  logic             dut_preset,
    input  logic             q,
    input  logic             qbar,
    output logic             err,
    output logic             err_sticky,
    output logic             illegal,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_CHECK = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Two-stage release synchroniser: clr asserts immediately, deasserts only after two edges.
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    state_e           state_q,      state_d;
    logic             exp_bit_q,    exp_bit_d;
    logic             exp_valid_q,  exp_valid_d;
    logic             err_q,        err_d;
    logic             err_sticky_q, err_sticky_d;
    logic             illegal_q,    illegal_d;
    logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q,    chk_cnt_d;

    // Decoded command as the flip-flop would see it this edge.
    logic cmd_bit;
    logic cmd_valid;
    logic cmd_illegal;
    logic compare;
    logic mismatch;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; a missing default on any branch would infer a latch.
    always_comb begin
        cmd_bit     = exp_bit_q;
        cmd_valid   = exp_valid_q;
        cmd_illegal = 1'b0;
        if (dut_clr) begin
            cmd_bit   = 1'b0;
            cmd_valid = 1'b1;
        end else if (dut_preset) begin
            cmd_bit   = 1'b1;
            cmd_valid = 1'b1;
        end else begin
            unique case ({s, r})
                2'b00: begin
                    cmd_bit   = exp_bit_q;
                    cmd_valid = exp_valid_q;
                end
                2'b01: begin
                    cmd_bit   = 1'b0;
                    cmd_valid = 1'b1;
                end
                2'b10: begin
                    cmd_bit   = 1'b1;
                    cmd_valid = 1'b1;
                end
                default: begin
                    cmd_bit     = exp_bit_q;
                    cmd_valid   = 1'b0;
                    cmd_illegal = 1'b1;
                end
            endcase
        end
    end

    // The registered prediction describes what q should be after the previous edge.
    assign compare  = run && en && (state_q == ST_CHECK) && exp_valid_q;
    assign mismatch = compare && ((q != exp_bit_q) || (qbar == q));

    always_comb begin
        state_d      = state_q;
        exp_bit_d    = exp_bit_q;
        exp_valid_d  = exp_valid_q;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        illegal_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
        chk_cnt_d    = chk_cnt_q;

        if (run) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en) state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (!en)            state_d = ST_IDLE;
                    else if (cmd_valid) state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (!en)                          state_d = ST_IDLE;
                    else if (mismatch && HALT_ON_ERR) state_d = ST_HALT;
                    else if (!cmd_valid)              state_d = ST_SYNC;
                end
                default: state_d = ST_HALT;
            endcase

            if (state_q != ST_HALT) begin
                if (en) begin
                    exp_bit_d   = cmd_bit;
                    exp_valid_d = cmd_valid;
                    illegal_d   = cmd_illegal;
                end else begin
                    exp_valid_d = 1'b0;
                end
            end

            if (compare && (chk_cnt_q != CNT_MAX)) chk_cnt_d = chk_cnt_q + CNT_ONE;

            if (mismatch) begin
                err_d        = 1'b1;
                err_sticky_d = 1'b1;
                if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= ST_IDLE;
            exp_bit_q    <= 1'b0;
            exp_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            illegal_q    <= 1'b0;
            err_cnt_q    <= '0;
            chk_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            exp_bit_q    <= exp_bit_d;
            exp_valid_q  <= exp_valid_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            illegal_q    <= illegal_d;
            err_cnt_q    <= err_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
        end
    end

    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign illegal    = illegal_q;
    assign err_cnt    = err_cnt_q;
    assign chk_cnt    = chk_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Directed bench for sr_ff_checker: three instances (default, halt-on-error, 2-bit counters)
// watch a behavioural SR flip-flop whose outputs can be corrupted per instance.
module tb_sr_ff_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr = 1'b1;
    logic en = 1'b0, s = 1'b0, r = 1'b0, dut_clr = 1'b0, dut_preset = 1'b0;

    // Correct flip-flop behaviour; s=r=1 simply holds.
    logic ref_q = 1'b0;
    always @(posedge clk) begin
        if (dut_clr)          ref_q <= 1'b0;
        else if (dut_preset)  ref_q <= 1'b1;
        else if (s && !r)     ref_q <= 1'b1;
        else if (!s && r)     ref_q <= 1'b0;
    end

    logic bad_q0 = 1'b0, bad_qb0 = 1'b0;
    logic bad_q1 = 1'b0, bad_qb1 = 1'b0;
    logic bad_q2 = 1'b0, bad_qb2 = 1'b0;
    logic q0, qb0, q1, qb1, q2, qb2;
    assign q0  = ref_q ^ bad_q0;
    assign qb0 = bad_qb0 ? q0 : ~q0;
    assign q1  = ref_q ^ bad_q1;
    assign qb1 = bad_qb1 ? q1 : ~q1;
    assign q2  = ref_q ^ bad_q2;
    assign qb2 = bad_qb2 ? q2 : ~q2;

    logic       err0, sticky0, ill0;
    logic [7:0] ecnt0, ccnt0;
    logic [1:0] st0;
    logic       err1, sticky1, ill1;
    logic [7:0] ecnt1, ccnt1;
    logic [1:0] st1;
    logic       err2, sticky2, ill2;
    logic [1:0] ecnt2, ccnt2;
    logic [1:0] st2;

    sr_ff_checker #(.CNT_W(8), .HALT_ON_ERR(1'b0)) u0 (
        .clk(clk), .clr(clr), .en(en), .s(s), .r(r), .dut_clr(dut_clr), .dut_preset(dut_preset),
        .q(q0), .qbar(qb0), .err(err0), .err_sticky(sticky0), .illegal(ill0),
        .err_cnt(ecnt0), .chk_cnt(ccnt0), .state(st0)
    );

    sr_ff_checker #(.CNT_W(8), .HALT_ON_ERR(1'b1)) u1 (
        .clk(clk), .clr(clr), .en(en), .s(s), .r(r), .dut_clr(dut_clr), .dut_preset(dut_preset),
        .q(q1), .qbar(qb1), .err(err1), .err_sticky(sticky1), .illegal(ill1),
        .err_cnt(ecnt1), .chk_cnt(ccnt1), .state(st1)
    );

    sr_ff_checker #(.CNT_W(2), .HALT_ON_ERR(1'b0)) u2 (
        .clk(clk), .clr(clr), .en(en), .s(s), .r(r), .dut_clr(dut_clr), .dut_preset(dut_preset),
        .q(q2), .qbar(qb2), .err(err2), .err_sticky(sticky2), .illegal(ill2),
        .err_cnt(ecnt2), .chk_cnt(ccnt2), .state(st2)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic c, input logic p, input logic sv, input logic rv);
        dut_clr    = c;
        dut_preset = p;
        s          = sv;
        r          = rv;
    endtask

    task automatic do_reset();
        en = 1'b0;
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0);
        {bad_q0, bad_qb0, bad_q1, bad_qb1, bad_q2, bad_qb2} = '0;
        clr = 1'b0;
        #2;
        tick();
        check("rst_state0",  st0,     2'b00);
        check("rst_err0",    err0,    1'b0);
        check("rst_sticky0", sticky0, 1'b0);
        check("rst_ill0",    ill0,    1'b0);
        check("rst_ecnt0",   ecnt0,   8'd0);
        check("rst_ccnt0",   ccnt0,   8'd0);
        check("rst_state2",  st2,     2'b00);
        clr = 1'b1;
        repeat (3) tick();
        check("post_rst_state0", st0, 2'b00);
    endtask

    initial begin
        #2;
        // Correct DUT through clear then the 10,00,01,00 sweep.
        do_reset();
        en = 1'b1; set_cmd(1'b1, 1'b0, 1'b0, 1'b0); tick();
        check("p1_sync",  st0,  2'b01);
        check("p1_err_a", err0, 1'b0);
        set_cmd(1'b0, 1'b0, 1'b1, 1'b0); tick();
        check("p1_check", st0,   2'b10);
        check("p1_ccnt0", ccnt0, 8'd0);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); tick();
        check("p1_ccnt1", ccnt0, 8'd1);
        check("p1_err_b", err0,  1'b0);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b1); tick();
        check("p1_err_c", err0,  1'b0);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); tick();
        check("p1_err_d", err0,  1'b0);
        tick();
        check("p1_ccnt4", ccnt0, 8'd4);
        check("p1_ecnt",  ecnt0, 8'd0);
        check("p1_err_e", err0,  1'b0);
        en = 1'b0; tick();
        check("p1_idle",      st0,     2'b00);
        check("p1_ccnt_hold", ccnt0,   8'd4);
        check("p1_sticky",    sticky0, 1'b0);

        // Same sweep, q wrong for the cycle after the 10 command.
        do_reset();
        en = 1'b1; set_cmd(1'b1, 1'b0, 1'b0, 1'b0); tick();
        set_cmd(1'b0, 1'b0, 1'b1, 1'b0); tick();
        check("p2_err_pre", err0, 1'b0);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); bad_q0 = 1'b1; tick();
        check("p2_err_pulse", err0,    1'b1);
        check("p2_sticky",    sticky0, 1'b1);
        check("p2_ecnt1",     ecnt0,   8'd1);
        bad_q0 = 1'b0;
        set_cmd(1'b0, 1'b0, 1'b0, 1'b1); tick();
        check("p2_err_low",   err0,    1'b0);
        check("p2_sticky_b",  sticky0, 1'b1);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); tick();
        tick();
        check("p2_ccnt4", ccnt0, 8'd4);
        check("p2_ecnt",  ecnt0, 8'd1);

        // Illegal s=r=1 in CHECK, then recover with a set command.
        set_cmd(1'b0, 1'b0, 1'b1, 1'b1); tick();
        check("p3_ill",      ill0,  1'b1);
        check("p3_sync",     st0,   2'b01);
        check("p3_ccnt5",    ccnt0, 8'd5);
        set_cmd(1'b0, 1'b0, 1'b1, 0); tick();
        check("p3_ill_off",  ill0,  1'b0);
        check("p3_ccnt_syn", ccnt0, 8'd5);
        check("p3_check",    st0,   2'b10);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); tick();
        check("p3_ccnt6",    ccnt0, 8'd6);
        check("p3_err",      err0,  1'b0);

        // clr and preset together with s=r=1: clear wins, not illegal.
        set_cmd(1'b1, 1'b1, 1'b1, 1'b1); tick();
        check("p4_no_ill", ill0,  1'b0);
        check("p4_check",  st0,   2'b10);
        check("p4_ccnt7",  ccnt0, 8'd7);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); tick();
        check("p4_err",    err0,  1'b0);
        check("p4_ccnt8",  ccnt0, 8'd8);
        check("p4_ecnt",   ecnt0, 8'd1);
        en = 1'b0; tick();
        check("p4_idle",   st0,   2'b00);
        check("p4_hold",   ccnt0, 8'd8);
        en = 1'b1; set_cmd(1'b0, 1'b0, 1'b1, 1'b1); tick();
        check("p4_exit_sync", st0,  2'b01);
        check("p4_exit_ill",  ill0, 1'b1);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); tick();
        check("p4_stay_sync", st0,  2'b01);
        check("p4_ill_off",   ill0, 1'b0);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b1); tick();
        check("p4_recheck",   st0,  2'b10);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); tick();
        check("p4_ccnt9",     ccnt0, 8'd9);

        // Halt-on-error instance with qbar tied equal to q.
        do_reset();
        en = 1'b1; set_cmd(1'b1, 1'b0, 1'b0, 1'b0); tick();
        set_cmd(1'b0, 1'b0, 1'b1, 1'b0); tick();
        check("p5_check", st1, 2'b10);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); bad_qb1 = 1'b1; tick();
        check("p5_err",   err1,  1'b1);
        check("p5_halt",  st1,   2'b11);
        check("p5_ecnt1", ecnt1, 8'd1);
        bad_q1 = 1'b1; tick();
        check("p5_err_off",  err1,  1'b0);
        check("p5_ecnt_frz", ecnt1, 8'd1);
        check("p5_ccnt_frz", ccnt1, 8'd1);
        en = 1'b0; set_cmd(1'b0, 1'b0, 1'b1, 1'b1); tick();
        check("p5_halt_en0", st1,  2'b11);
        check("p5_no_ill",   ill1, 1'b0);
        clr = 1'b0; #2;
        check("p5_clr_state",  st1,     2'b00);
        check("p5_clr_ecnt",   ecnt1,   8'd0);
        check("p5_clr_ccnt",   ccnt1,   8'd0);
        check("p5_clr_sticky", sticky1, 1'b0);

        // Two-bit counters against a permanently inverted q.
        do_reset();
        bad_q2 = 1'b1;
        en = 1'b1; set_cmd(1'b1, 1'b0, 1'b0, 1'b0); tick();
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0); tick();
        check("p6_check", st2, 2'b10);
        tick();
        check("p6_ecnt1", ecnt2, 2'd1);
        check("p6_err",   err2,  1'b1);
        tick(); tick();
        check("p6_ecnt3", ecnt2, 2'd3);
        tick(); tick(); tick();
        check("p6_ecnt_sat", ecnt2,   2'd3);
        check("p6_ccnt_sat", ccnt2,   2'd3);
        check("p6_sticky",   sticky2, 1'b1);
        check("p6_no_halt",  st2,     2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sr_ff_checker.md
# sr_ff_checker

Synthesizable checker that sits on the far side of an SR flip-flop under test: it observes the same s/r/clear/preset stimulus the DUT receives and predicts the DUT's next q. It compares that prediction against the DUT's q and qbar every cycle and reports mismatches, illegal s=r=1 commands and running counts. It sits beside the flip-flop in bench or FPGA self-test builds and needs no testbench-side reference model.

## Interface
- CNT_W, 8: width of the error and check counters; both saturate at 2^CNT_W-1.
- HALT_ON_ERR, 0: when 1, the first mismatch freezes the checker in HALT.
- clk  in  1  single clock; DUT and checker share it, rising edge.
- clr  in  1  asynchronous, active-low checker reset.
- en  in  1  enables checking; sampled each edge.
- s  in  1  DUT set input, as driven to DUT.
- r  in  1  DUT reset input, as driven to DUT.
- dut_clr  in  1  DUT synchronous clear, active-high; highest priority.
- dut_preset  in  1  DUT synchronous preset, active-high; below dut_clr.
- q  in  1  DUT output.
- qbar  in  1  DUT complementary output.
- err  out  1  one-cycle pulse on mismatch.
- err_sticky  out  1  set on first mismatch, cleared only by clr.
- illegal  out  1  one-cycle pulse: s=r=1 sampled with dut_clr=dut_preset=0.
- err_cnt  out  CNT_W  mismatches counted.
- chk_cnt  out  CNT_W  cycles actually compared.
- state  out  2  00 IDLE, 01 SYNC, 10 CHECK, 11 HALT.

## Operation
- Reference model: exp_q, exp_valid registered. At each edge with en=1: dut_clr -> exp_q=0, valid=1; else dut_preset -> exp_q=1, valid=1; else {s,r}=00 hold, 01 -> 0 (valid=1), 10 -> 1 (valid=1), 11 -> valid=0, illegal pulses.
- Compare, in CHECK with exp_valid=1 and en=1: mismatch if q != exp_q or qbar != ~q. Both are sampled at the edge following the model update.
- A mismatch pulses err for one cycle, sets err_sticky and increments err_cnt. Every compare increments chk_cnt. Both counters saturate with no wrap.
- States:
  - IDLE: en=1 -> SYNC.
  - SYNC: model updates and nothing is compared. Moves to CHECK at the edge where exp_valid becomes 1.
  - CHECK: exp_valid falls (s=r=1) -> SYNC. en=0 -> IDLE. Mismatch with HALT_ON_ERR=1 -> HALT.
  - HALT: terminal until clr. Counters, model and err are frozen, and err is 0.
- en=0 in any state other than HALT -> IDLE and exp_valid=0. Counters hold.
- Simultaneous events: dut_clr beats dut_preset beats s/r. dut_clr=1 with s=r=1 is legal, so illegal does not pulse.
- illegal pulses in SYNC, CHECK and IDLE-exit cycles whenever en=1; never in HALT.

## Timing
- Reset (clr=0, async): state=IDLE, exp_q=0, exp_valid=0, err=0, err_sticky=0, illegal=0, err_cnt=0, chk_cnt=0. All outputs are registered.
- Stimulus sampled at edge N updates exp_q at N. DUT q sampled at edge N+1 is compared against it, and err is visible after edge N+1 (1-cycle latency).
- illegal is visible after the edge that samples s=r=1.
- First compare happens at the edge after SYNC->CHECK.
- clr asserted mid-run clears everything immediately. Release of clr is synchronised internally, so the first state change occurs no earlier than the second edge after release.

## Test plan
- Reset, en=1, dut_clr=1 for 1 cycle, then s/r sweep 10,00,01,00 with a correct DUT -> state IDLE->SYNC->CHECK, err never 1, chk_cnt=4, err_cnt=0.
- Same sweep with DUT q forced to 0 during the 10 command -> one err pulse one cycle after the wrong q, err_sticky=1, err_cnt=1.
- In CHECK, drive s=r=1 for 1 cycle, then s=1, r=0 -> illegal pulses once, state CHECK->SYNC->CHECK, no compare during SYNC, chk_cnt unchanged for that cycle.
- dut_clr=1, dut_preset=1, s=r=1 together -> exp_q=0, no illegal. DUT q=0 gives no err.
- HALT_ON_ERR=1, force qbar=q -> err pulse, state=11, further mismatches leave err_cnt=1. Pulsing clr low returns state=00 and all counters to 0.
- CNT_W=2 with a continuously wrong DUT for 6 compares -> err_cnt saturates at 3, err_sticky stays 1.
